// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_reg
// Purpose  : Elastic pipeline stage register with valid/ready handshake,
//            two-entry skid buffer, synchronous flush, NOP bubble insertion
//            and saturating stall/flush performance counters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_stalled;

  // Ready depends only on registered state, so back-pressure never chains
  // combinationally between stages. Reset masks every output to the idle view.
  assign in_ready   = (r_state != ST_FULL) & ~RST;
  assign out_valid  = (r_state != ST_EMPTY) & ~RST;
  assign out_data   = out_valid ? r_main : NOP_VAL;
  assign occupancy  = RST ? 2'd0 : r_state;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_stalled  = out_valid & ~out_ready;

  // Next-state and data-path selection; flush overrides any handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (CLR) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = NOP_VAL;
      w_skid_nxt  = NOP_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt  = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_main_nxt  = NOP_VAL;
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = NOP_VAL;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = NOP_VAL;
          w_skid_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_EMPTY;
      r_main  <= NOP_VAL;
      r_skid  <= NOP_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Saturating stall counter; a flush cycle still counts if it was stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (w_stalled && (stall_cnt != c_cnt_max)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Saturating flush counter; only flushes that actually squash entries count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_cnt <= '0;
    end else if (CLR && (occupancy != 2'd0) && (flush_cnt != c_cnt_max)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid_reg
// Purpose  : Self-checking bench for pipe_stage_skid_reg: queue reference
//            model with scoreboard, directed vector table, corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] NOP = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_stage_skid_reg #(
    .DATA_W (DW),
    .NOP_VAL(NOP),
    .CNT_W  (CW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CLR      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          clr;
    bit          iv;
    logic [15:0] d;
    bit          ordy;
    bit          e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_occ;
    bit          e_ir;
    int          e_stall;
    int          e_flush;
  } vec_t;

  vec_t        tbl[12];
  logic [15:0] mq[$];
  int          m_stall;
  int          m_flush;
  bit          cnt_known;
  int          checks;
  int          errors;

  // current-cycle model view
  bit          m_ir;
  bit          m_ov;
  logic [15:0] m_od;
  logic [1:0]  m_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit v, input logic [15:0] d, input bit o);
    rst       = r;
    clr       = c;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
  endtask

  // Called at the negedge: compare DUT to the model and scoreboard.
  task automatic eval();
    m_ir  = (mq.size() < 2) && !rst;
    m_ov  = (mq.size() > 0) && !rst;
    m_od  = m_ov ? mq[0] : NOP;
    m_occ = rst ? 2'd0 : 2'(mq.size());
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", {16'd0, out_data}, {16'd0, m_od});
    chk("occupancy", {30'd0, occupancy}, {30'd0, m_occ});
    if (cnt_known) begin
      chk("stall_cnt", {28'd0, stall_cnt}, 32'(m_stall));
      chk("flush_cnt", {28'd0, flush_cnt}, 32'(m_flush));
    end
  endtask

  // Apply the clock edge to the model, then advance to just after it.
  task automatic commit();
    logic [15:0] exp_d;
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (m_ov && !out_ready && m_stall < 15) m_stall++;
      if (clr) begin
        if (mq.size() != 0 && m_flush < 15) m_flush++;
        mq.delete();
      end else begin
        if (m_ov && out_ready) begin
          exp_d = mq.pop_front();
          chk("sb_data", {16'd0, out_data}, {16'd0, exp_d});
        end
        if (in_valid && m_ir) mq.push_back(in_data);
      end
    end
    @(posedge clk);
    if (rst) cnt_known = 1'b1;
    #1;
  endtask

  task automatic step(input bit r, input bit c, input bit v, input logic [15:0] d, input bit o);
    drive(r, c, v, d, o);
    @(negedge clk);
    eval();
    commit();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_stall   = 0;
    m_flush   = 0;
    cnt_known = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0);

    // Directed skid and flush sequence with explicit expected outputs.
    tbl[0]  = '{0, 1, 16'h00A1, 1, 0, NOP,     2'd0, 1, 0, 0};
    tbl[1]  = '{0, 1, 16'h00B2, 0, 1, 16'h00A1, 2'd1, 1, 0, 0};
    tbl[2]  = '{0, 1, 16'h00C3, 0, 1, 16'h00A1, 2'd2, 0, 1, 0};
    tbl[3]  = '{0, 1, 16'h00C3, 0, 1, 16'h00A1, 2'd2, 0, 2, 0};
    tbl[4]  = '{0, 1, 16'h00C3, 1, 1, 16'h00A1, 2'd2, 0, 3, 0};
    tbl[5]  = '{0, 1, 16'h00C3, 1, 1, 16'h00B2, 2'd1, 1, 3, 0};
    tbl[6]  = '{0, 0, 16'h0000, 1, 1, 16'h00C3, 2'd1, 1, 3, 0};
    tbl[7]  = '{0, 0, 16'h0000, 1, 0, NOP,     2'd0, 1, 3, 0};
    tbl[8]  = '{0, 1, 16'h00A1, 0, 0, NOP,     2'd0, 1, 3, 0};
    tbl[9]  = '{0, 1, 16'h00B2, 0, 1, 16'h00A1, 2'd1, 1, 3, 0};
    tbl[10] = '{1, 1, 16'h00D4, 0, 1, 16'h00A1, 2'd2, 0, 4, 0};
    tbl[11] = '{0, 0, 16'h0000, 1, 0, NOP,     2'd0, 1, 5, 1};

    @(posedge clk);
    #1;

    // Reset held two cycles with upstream offering data.
    step(1'b1, 1'b0, 1'b1, 16'h1111, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h2222, 1'b0);

    // Streaming: 1..8 back to back, then drain.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 16'(i), 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("stream_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("stream_empty", {30'd0, occupancy}, 32'd0);

    // Table-driven skid and flush sequence.
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_od", i), {16'd0, out_data}, {16'd0, tbl[i].e_od});
      chk($sformatf("tbl%0d_occ", i), {30'd0, occupancy}, {30'd0, tbl[i].e_occ});
      chk($sformatf("tbl%0d_ir", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
      chk($sformatf("tbl%0d_stall", i), {28'd0, stall_cnt}, 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_flush", i), {28'd0, flush_cnt}, 32'(tbl[i].e_flush));
      eval();
      commit();
    end

    // Saturation: one beat held against a stalled consumer for 20 cycles.
    step(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    eval();
    commit();

    // Reset while FULL.
    step(1'b0, 1'b0, 1'b1, 16'h0E01, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0E02, 1'b0);
    chk("midop_full", {30'd0, occupancy}, 32'd2);
    step(1'b1, 1'b0, 1'b1, 16'h0E03, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    chk("midop_occ", {30'd0, occupancy}, 32'd0);
    chk("midop_stall", {28'd0, stall_cnt}, 32'd0);
    chk("midop_flush", {28'd0, flush_cnt}, 32'd0);
    chk("midop_in_ready", {31'd0, in_ready}, 32'd1);
    eval();
    commit();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 97) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
           16'($urandom), ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
